// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
//   Shared helpers for the round-robin RAM access controller.
//   - next_rr_idx  : modulo-n increment used to walk the round-robin ring
//   - rr_reset_idx : pointer value loaded at reset (last index, so index 0
//                    is searched first)
package ram_ctrl_pkg;

  function automatic int next_rr_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

  function automatic int rr_reset_idx(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   N-way round-robin arbiter. The pointer holds the last granted index; the
//   search starts one past it and wraps. The pointer moves only on a grant.
//   Ports:
//     clk_i, rstn_i  : clock, asynchronous active-low reset
//     req_i[N]       : request vector
//     gnt_o[N]       : one-hot grant (all zero while in reset or idle)
//     gnt_id_o       : index of the granted requester
//     gnt_valid_o    : a grant was issued this cycle
module rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            gnt_valid_o
);

  localparam logic [ID_W-1:0] PTR_RST = ID_W'(rr_reset_idx(N));

  logic [ID_W-1:0] ptr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q <= PTR_RST;
    end else if (gnt_valid_o) begin
      ptr_q <= gnt_id_o;
    end
  end

  always_comb begin
    int              cand;
    logic [ID_W-1:0] cand_id;
    logic            found;
    gnt_o       = '0;
    gnt_id_o    = '0;
    gnt_valid_o = 1'b0;
    found       = 1'b0;
    cand        = next_rr_idx(int'(ptr_q), N);
    cand_id     = '0;
    for (int k = 0; k < N; k++) begin
      cand_id = ID_W'(cand);
      if (!found && req_i[cand_id]) begin
        found          = 1'b1;
        gnt_o[cand_id] = 1'b1;
        gnt_id_o       = cand_id;
      end
      cand = next_rr_idx(cand, N);
    end
    gnt_valid_o = found;
    // No grants while reset is held, even if requesters are asserting valid.
    if (!rstn_i) begin
      gnt_o       = '0;
      gnt_id_o    = '0;
      gnt_valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/ram_rr_ctrl.sv
// ram_rr_ctrl
//   Shares one simple dual-port byte-enable RAM (write port A, registered
//   read port B with 1-cycle latency) among N_REQ requesters. Writes and
//   reads are arbitrated independently, so one of each can be granted per
//   cycle. Read data returns to the grantee one cycle later.
//   Ports:
//     clk_i, rstn_i            : clock, asynchronous active-low reset
//     req_valid_i/req_ready_o  : per-requester handshake (ready is
//                                combinational from valid)
//     req_we_i, req_be_i,
//     req_addr_i, req_wdata_i  : per-requester payload
//     rsp_valid_o              : one-hot read-data strobe
//     rsp_rdata_o              : shared read data (zero when not valid or
//                                when the address was out of range)
//     ram_we_o, ram_be_o,
//     ram_addr_a_o, ram_data_a_o : RAM write port
//     ram_addr_b_o, ram_data_b_i : RAM read port
module ram_rr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter  int N_REQ         = 2,
  parameter  int BYTE_WIDTH    = 8,
  parameter  int BYTES_IN_WORD = 4,
  parameter  int WORD_COUNT    = 256,
  localparam int ADDR_WIDTH    = $clog2(WORD_COUNT),
  localparam int WORD_WIDTH    = BYTE_WIDTH * BYTES_IN_WORD,
  localparam int ID_WIDTH      = $clog2(N_REQ)
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic [N_REQ-1:0]                      req_valid_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  input  logic [N_REQ-1:0]                      req_we_i,
  input  logic [N_REQ-1:0][BYTES_IN_WORD-1:0]   req_be_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [N_REQ-1:0][WORD_WIDTH-1:0]      req_wdata_i,
  output logic [N_REQ-1:0]                      rsp_valid_o,
  output logic [WORD_WIDTH-1:0]                 rsp_rdata_o,
  output logic                                  ram_we_o,
  output logic [BYTES_IN_WORD-1:0]              ram_be_o,
  output logic [ADDR_WIDTH-1:0]                 ram_addr_a_o,
  output logic [WORD_WIDTH-1:0]                 ram_data_a_o,
  output logic [ADDR_WIDTH-1:0]                 ram_addr_b_o,
  input  logic [WORD_WIDTH-1:0]                 ram_data_b_i
);

  // Depth need not be a power of two, so addresses above the last word are
  // representable and must be filtered.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH + 1)'(WORD_COUNT);
  endfunction

  logic [N_REQ-1:0]    wr_req, rd_req;
  logic [N_REQ-1:0]    wr_gnt, rd_gnt;
  logic [ID_WIDTH-1:0] wr_gnt_id, rd_gnt_id;
  logic                wr_gnt_valid, rd_gnt_valid;

  assign wr_req = req_valid_i & req_we_i;
  assign rd_req = req_valid_i & ~req_we_i;

  rr_arbiter #(.N(N_REQ)) u_wr_arb (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_i       (wr_req),
    .gnt_o       (wr_gnt),
    .gnt_id_o    (wr_gnt_id),
    .gnt_valid_o (wr_gnt_valid)
  );

  rr_arbiter #(.N(N_REQ)) u_rd_arb (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_i       (rd_req),
    .gnt_o       (rd_gnt),
    .gnt_id_o    (rd_gnt_id),
    .gnt_valid_o (rd_gnt_valid)
  );

  // A requester sits in exactly one class per cycle, so OR-ing is safe.
  assign req_ready_o = wr_gnt | rd_gnt;

  // ---- stage p0: grant, payload mux, RAM port drive ----
  // Gating by the grant valid zeroes the RAM ports when idle or in reset.
  assign ram_be_o     = wr_gnt_valid ? req_be_i[wr_gnt_id]    : '0;
  assign ram_addr_a_o = wr_gnt_valid ? req_addr_i[wr_gnt_id]  : '0;
  assign ram_data_a_o = wr_gnt_valid ? req_wdata_i[wr_gnt_id] : '0;
  assign ram_we_o     = wr_gnt_valid & addr_in_range(ram_addr_a_o) & (|ram_be_o);
  assign ram_addr_b_o = rd_gnt_valid ? req_addr_i[rd_gnt_id]  : '0;

  // ---- stage p1: read response, aligned with registered RAM data ----
  logic                rsp_vld_p1;
  logic [ID_WIDTH-1:0] rsp_id_p1;
  logic                rsp_oor_p1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_vld_p1 <= 1'b0;
    end else begin
      rsp_vld_p1 <= rd_gnt_valid;
    end
  end

  // Qualified by rsp_vld_p1, so these carry no reset.
  always_ff @(posedge clk_i) begin
    rsp_id_p1  <= rd_gnt_id;
    rsp_oor_p1 <= !addr_in_range(ram_addr_b_o);
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid_o[i] = rsp_vld_p1 && (rsp_id_p1 == ID_WIDTH'(i));
    end
  end

  assign rsp_rdata_o = (rsp_vld_p1 && !rsp_oor_p1) ? ram_data_b_i : '0;

endmodule

// File: doc/ram_rr_ctrl.md
# ram_rr_ctrl

Round-robin access controller that shares one simple dual-port, byte-enable RAM (one write port, one registered read port, 1-cycle read latency) among `N_REQ` requesters. Writes and reads are arbitrated independently, so one write and one read can be granted each cycle. Read data returns to the granted requester one cycle later with a valid strobe. The block sits between CPU, DMA or accelerator masters and a shared RAM instance.

## Interface
- `N_REQ`, 2, number of requesters (≥2)
- `BYTE_WIDTH`, 8, bits per byte lane
- `BYTES_IN_WORD`, 4, byte lanes per word
- `WORD_COUNT`, 256, RAM depth in words
- localparams: `ADDR_WIDTH = $clog2(WORD_COUNT)`, `WORD_WIDTH = BYTE_WIDTH*BYTES_IN_WORD`, `ID_WIDTH = $clog2(N_REQ)`

Ports:
- `clk_i` in 1: single clock
- `rstn_i` in 1: reset, asynchronous, active-low
- `req_valid_i` in [N_REQ]: request valid per requester
- `req_ready_o` out [N_REQ]: request accepted this cycle
- `req_we_i` in [N_REQ]: 1 = write, 0 = read
- `req_be_i` in [N_REQ][BYTES_IN_WORD]: write byte enables
- `req_addr_i` in [N_REQ][ADDR_WIDTH]: word address
- `req_wdata_i` in [N_REQ][WORD_WIDTH]: write data
- `rsp_valid_o` out [N_REQ]: one-cycle read-data strobe per requester
- `rsp_rdata_o` out WORD_WIDTH: read data, shared by all requesters, qualified by `rsp_valid_o`
- `ram_we_o`, `ram_be_o`, `ram_addr_a_o`, `ram_data_a_o` out: RAM write port
- `ram_addr_b_o` out ADDR_WIDTH: RAM read address
- `ram_data_b_i` in WORD_WIDTH: RAM read data, registered, valid the cycle after the address

## Operation
- Handshake: a transfer occurs when `req_valid_i[i] & req_ready_o[i]`.
  - Requesters hold valid and payload stable until accepted.
  - `req_ready_o` depends combinationally on `req_valid_i`. Requesters must not make valid depend on ready.
- Write arbiter: considers requesters with `valid & we`. Exactly one is granted per cycle, by round-robin.
  - Grantee payload drives the RAM write port the same cycle.
  - `ram_we_o` = grant & (addr < WORD_COUNT) & (|be).
- Read arbiter: considers requesters with `valid & !we`. Exactly one is granted per cycle, by round-robin. Grantee address drives `ram_addr_b_o`.
- Round-robin: each arbiter keeps a pointer to the last granted index.
  - Search starts at pointer+1 and wraps modulo N_REQ.
  - The pointer updates only on a grant. Idle cycles leave it unchanged.
- Read response pipeline registers: grant valid, grantee id, and an out-of-range flag.
  - Next cycle: `rsp_valid_o[id]` = 1 and `rsp_rdata_o` = `ram_data_b_i`, or all-zero if the address was out of range.
- Boundaries:
  - Write with `be == 0`: accepted and ready pulses, but no RAM write.
  - Address ≥ WORD_COUNT (non-power-of-2 depth): write accepted and dropped; read accepted and returns zero.
  - Same-cycle write and read to the same address: no forwarding; the read returns the pre-write contents.
  - Back-to-back reads from one requester with no competition: granted every cycle, one response per cycle.
  - `rsp_valid_o` is never asserted to two requesters in the same cycle.
- Reset (async assert, any time including mid-transfer):
  - Both pointers go to N_REQ-1, so requester 0 has first priority.
  - Response pipeline is cleared. A read in flight at reset produces no response.
  - While `rstn_i` = 0: `req_ready_o` = 0, `ram_we_o` = 0, `rsp_valid_o` = 0, `rsp_rdata_o` = 0. Address and data outputs = 0.

## Timing
- Grant/ready: 0 cycles, combinational from valid, through the arbiter, to the RAM ports.
- Read latency: request accepted in cycle T, `rsp_valid_o` in cycle T+1.
- Write visible to a read issued in cycle T+1 or later.
- Throughput: 1 write + 1 read per cycle in aggregate.
- Fairness: a continuously valid requester waits at most N_REQ-1 grants of its class.
- The only state is 2 pointers (ID_WIDTH each) and the response register (1 + ID_WIDTH + 1 bits plus rdata mux). No FSM beyond the pointers.

## Structure
- Package `ram_ctrl_pkg`:
  - helper `next_rr_idx` for modulo-N increment
  - reset-pointer constant
- Sub-module `rr_arbiter`:
  - parameter N
  - ports `clk_i`, `rstn_i`, `req_i[N]`, `gnt_o[N]` (one-hot), `gnt_id_o`, `gnt_valid_o`
  - instantiated twice, once for writes and once for reads
- Top level: class masking, payload muxes, range check, response pipeline.

## Test plan
- **Reset then single read:** preload addr 0x10 = 0xDEADBEEF; req1 reads 0x10. Expected: `req_ready_o[1]` in the same cycle, `rsp_valid_o` = 2'b10 and rdata 0xDEADBEEF one cycle later.
- **Byte-enable write:** req0 writes 0x11223344, be = 4'b0101, to addr 5 (old 0xAABBCCDD), then reads it. Expected: 0xAA22CC44. Write with be = 0 leaves the word unchanged.
- **Contention fairness:** N_REQ = 3, all three read continuously for 9 cycles. Expected: grant order 0,1,2,0,1,2,…, each `rsp_valid_o` one-hot, three responses each.
- **Concurrent classes:** req0 writes 0x55 to addr 7 while req1 reads addr 7 in the same cycle. Expected: both ready; req1 gets the old value; a read one cycle later returns 0x55.
- **Out-of-range:** WORD_COUNT = 200; write to addr 250, then read addr 250. Expected: `ram_we_o` stays 0; response rdata = 0.
- **Reset mid-read:** assert `rstn_i` low the cycle after a read grant. Expected: no `rsp_valid_o`. After release, pointers restart so requester 0 wins a 0/1 tie.
